// File: rtl/clint_timer_master.sv
// Bus master that reads the 64-bit CLINT mtime with a hi/lo/hi tear check
// and writes mtimecmp0 with the glitch-free lo-max / hi / lo sequence.
module clint_timer_master #(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          MAX_RETRY = 3,
    parameter int          XLEN      = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic            i_cmd_op,
    input  logic [63:0]     i_cmd_wdata,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [63:0]     o_rsp_rdata,
    output logic            o_rsp_err,
    output logic            o_wen,
    output logic            o_ren,
    output logic [XLEN-1:0] o_addr,
    output logic [XLEN-1:0] o_wrdata,
    input  logic [XLEN-1:0] i_rddata
);

    localparam logic [31:0] ADDR_CMP_LO   = BASE_ADDR + 32'h0000_4000;
    localparam logic [31:0] ADDR_CMP_HI   = BASE_ADDR + 32'h0000_4004;
    localparam logic [31:0] ADDR_MTIME_LO = BASE_ADDR + 32'h0000_BFF8;
    localparam logic [31:0] ADDR_MTIME_HI = BASE_ADDR + 32'h0000_BFFC;
    localparam int          RW            = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE, RD_HI1, RD_LO, RD_HI2, WR_LO_MAX, WR_HI, WR_LO, RESP
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    hi_a_q, hi_a_d;
    logic [31:0]    lo_q, lo_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic [63:0]    wdata_q, wdata_d;
    logic [63:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    // Held low through reset so the master cannot accept until one edge after release.
    logic           rdy_en_q;

    logic [31:0]    rd_word;
    assign rd_word     = i_rddata[31:0];
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            hi_a_q   <= '0;
            lo_q     <= '0;
            retry_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_a_q   <= hi_a_d;
            lo_q     <= lo_d;
            retry_q  <= retry_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        hi_a_d      = hi_a_q;
        lo_d        = lo_q;
        retry_d     = retry_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        o_cmd_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_wen       = 1'b0;
        o_ren       = 1'b0;
        o_addr      = '0;
        o_wrdata    = '0;

        case (state_q)
            IDLE: begin
                o_cmd_ready = rdy_en_q;
                if (i_cmd_valid && rdy_en_q) begin
                    retry_d = '0;
                    wdata_d = i_cmd_wdata;
                    state_d = i_cmd_op ? WR_LO_MAX : RD_HI1;
                end
            end
            RD_HI1: begin
                o_ren   = 1'b1;
                o_addr  = XLEN'(ADDR_MTIME_HI);
                hi_a_d  = rd_word;
                state_d = RD_LO;
            end
            RD_LO: begin
                o_ren   = 1'b1;
                o_addr  = XLEN'(ADDR_MTIME_LO);
                lo_d    = rd_word;
                state_d = RD_HI2;
            end
            RD_HI2: begin
                o_ren  = 1'b1;
                o_addr = XLEN'(ADDR_MTIME_HI);
                if (rd_word == hi_a_q) begin
                    rdata_d = {hi_a_q, lo_q};
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (retry_q == RW'(MAX_RETRY)) begin
                    rdata_d = {rd_word, lo_q};
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    // High word rolled over between reads: resample lo against the new hi.
                    hi_a_d  = rd_word;
                    retry_d = retry_q + RW'(1);
                    state_d = RD_LO;
                end
            end
            WR_LO_MAX: begin
                o_wen    = 1'b1;
                o_addr   = XLEN'(ADDR_CMP_LO);
                o_wrdata = XLEN'(32'hFFFF_FFFF);
                state_d  = WR_HI;
            end
            WR_HI: begin
                o_wen    = 1'b1;
                o_addr   = XLEN'(ADDR_CMP_HI);
                o_wrdata = XLEN'(wdata_q[63:32]);
                state_d  = WR_LO;
            end
            WR_LO: begin
                o_wen    = 1'b1;
                o_addr   = XLEN'(ADDR_CMP_LO);
                o_wrdata = XLEN'(wdata_q[31:0]);
                rdata_d  = '0;
                err_d    = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_clint_timer_master.sv
// Scoreboard bench for clint_timer_master: a scripted mtime bus slave, an
// expected-write queue and an expected-response queue.
module tb_clint_timer_master;

    localparam logic [31:0] CMP_LO   = 32'h2000_4000;
    localparam logic [31:0] CMP_HI   = 32'h2000_4004;
    localparam logic [31:0] MTIME_LO = 32'h2000_BFF8;
    localparam logic [31:0] MTIME_HI = 32'h2000_BFFC;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_cmd_valid, o_cmd_ready, i_cmd_op;
    logic [63:0] i_cmd_wdata;
    logic        o_rsp_valid, i_rsp_ready;
    logic [63:0] o_rsp_rdata;
    logic        o_rsp_err, o_wen, o_ren;
    logic [31:0] o_addr, o_wrdata, i_rddata;

    always #5 clk = ~clk;

    clint_timer_master dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_wdata (i_cmd_wdata),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_wen       (o_wen),
        .o_ren       (o_ren),
        .o_addr      (o_addr),
        .o_wrdata    (o_wrdata),
        .i_rddata    (i_rddata)
    );

    typedef struct {logic [63:0] rdata; logic err; int lat;} rsp_t;
    typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;

    rsp_t        sb_q[$];
    wr_t         wr_q[$];
    logic [31:0] hi_q[$];
    logic [31:0] lo_q[$];
    logic [31:0] hi_head = 32'h0;
    logic [31:0] lo_head = 32'h0;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    assign i_rddata = !o_ren               ? 32'h0 :
                      (o_addr == MTIME_HI) ? hi_head :
                      (o_addr == MTIME_LO) ? lo_head : 32'hDEAD_BEEF;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus slave: the head word for this cycle's read is presented before the sampling edge.
    always @(negedge clk) begin
        wr_t w;
        if (o_wen || o_ren) check_val("strobe_excl", 64'(o_wen & o_ren), 64'd0);
        if (o_ren) begin
            if (o_addr == MTIME_HI) begin
                if (hi_q.size() == 0) check_val("rd_hi_extra", 64'd1, 64'd0);
                else hi_head = hi_q.pop_front();
            end else if (o_addr == MTIME_LO) begin
                if (lo_q.size() == 0) check_val("rd_lo_extra", 64'd1, 64'd0);
                else lo_head = lo_q.pop_front();
            end else begin
                check_val("rd_addr", 64'(o_addr), 64'(MTIME_HI));
            end
        end
        if (o_wen) begin
            if (wr_q.size() == 0) begin
                check_val("wr_extra", 64'(o_addr), 64'd0);
            end else begin
                w = wr_q.pop_front();
                check_val("wr_addr", 64'(o_addr), 64'(w.addr));
                check_val("wr_data", 64'(o_wrdata), 64'(w.data));
            end
        end
    end

    task automatic push_writes(input logic [63:0] wd);
        wr_q.push_back('{CMP_LO, 32'hFFFF_FFFF});
        wr_q.push_back('{CMP_HI, wd[63:32]});
        wr_q.push_back('{CMP_LO, wd[31:0]});
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_rvalid"}, 64'(o_rsp_valid), 64'd0);
        check_val({tag, "_wen"},    64'(o_wen),       64'd0);
        check_val({tag, "_ren"},    64'(o_ren),       64'd0);
        check_val({tag, "_addr"},   64'(o_addr),      64'd0);
        check_val({tag, "_wrdata"}, 64'(o_wrdata),    64'd0);
        check_val({tag, "_rdata"},  o_rsp_rdata,      64'd0);
        check_val({tag, "_err"},    64'(o_rsp_err),   64'd0);
        check_val({tag, "_ready"},  64'(o_cmd_ready), 64'd0);
    endtask

    // Called at a negedge with the DUT idle; drives one command and consumes its response.
    task automatic do_cmd(input logic op, input logic [63:0] wd, input logic [63:0] er,
                          input logic ee, input int lat, input int hold);
        rsp_t e;
        int   n;
        int   t_acc;
        sb_q.push_back('{er, ee, lat});
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_wdata = wd;
        n = 0;
        while (!o_cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!o_cmd_ready) begin
            check_val("accept_timeout", 64'd0, 64'd1);
            i_cmd_valid = 1'b0;
            void'(sb_q.pop_front());
            return;
        end
        t_acc = cyc + 1;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        n = 0;
        while (!o_rsp_valid && n < 40) begin @(negedge clk); n++; end
        if (!o_rsp_valid) begin
            check_val("rsp_timeout", 64'd0, 64'd1);
            void'(sb_q.pop_front());
            return;
        end
        check_val("rsp_latency", 64'(cyc - t_acc + 1), 64'(sb_q[0].lat));
        if (hold > 0) begin
            i_cmd_valid = 1'b1;
            i_cmd_op    = 1'b1;
            i_cmd_wdata = {$urandom, $urandom};
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check_val("hold_valid", 64'(o_rsp_valid), 64'd1);
                check_val("hold_rdata", o_rsp_rdata, sb_q[0].rdata);
                check_val("hold_err",   64'(o_rsp_err), 64'(sb_q[0].err));
                check_val("hold_ready", 64'(o_cmd_ready), 64'd0);
                check_val("hold_bus",   64'(o_wen | o_ren), 64'd0);
            end
        end
        i_rsp_ready = 1'b1;
        e = sb_q.pop_front();
        check_val("rsp_rdata", o_rsp_rdata, e.rdata);
        check_val("rsp_err",   64'(o_rsp_err), 64'(e.err));
        $display("[TB] op=%0d wdata=0x%016h -> rdata=0x%016h err=%0d lat=%0d",
                 op, wd, o_rsp_rdata, o_rsp_err, cyc - t_acc + 1);
        @(negedge clk);
        i_rsp_ready = 1'b0;
        check_val("rsp_dropped", 64'(o_rsp_valid), 64'd0);
        check_val("idle_ready",  64'(o_cmd_ready), 64'd1);
        i_cmd_valid = 1'b0;
        check_val("wr_pending", 64'(wr_q.size()), 64'd0);
        check_val("rd_pending", 64'(hi_q.size() + lo_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] rh, rl;
        logic [63:0] wd;
        int          n;
        i_rst       = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 1'b0;
        i_cmd_wdata = 64'd0;
        i_rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        i_rst = 1'b1;
        @(negedge clk);
        check_val("ready_after_rst", 64'(o_cmd_ready), 64'd1);

        // Clean read: hi/lo/hi agree.
        hi_q = '{32'h1, 32'h1};
        lo_q = '{32'h8000_0000};
        do_cmd(1'b0, 64'd0, 64'h0000_0001_8000_0000, 1'b0, 4, 0);

        // One rollover, then agreement.
        hi_q = '{32'h1, 32'h2, 32'h2};
        lo_q = '{32'hFFFF_FFFF, 32'h3};
        do_cmd(1'b0, 64'd0, 64'h0000_0002_0000_0003, 1'b0, 6, 0);

        // High word changes on every re-check: retry limit exhausted.
        hi_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        lo_q = '{32'h10, 32'h11, 32'h12, 32'h13};
        do_cmd(1'b0, 64'd0, 64'h0000_0005_0000_0013, 1'b1, 10, 0);

        // mtimecmp0 write sequence.
        push_writes(64'h0000_0005_0000_0010);
        do_cmd(1'b1, 64'h0000_0005_0000_0010, 64'd0, 1'b0, 4, 0);

        // Response back-pressure with a competing command request.
        hi_q = '{32'h7, 32'h7};
        lo_q = '{32'h9};
        do_cmd(1'b0, 64'd0, 64'h0000_0007_0000_0009, 1'b0, 4, 5);

        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 1) begin
                wd = {$urandom, $urandom};
                push_writes(wd);
                do_cmd(1'b1, wd, 64'd0, 1'b0, 4, 0);
            end else begin
                rh = $urandom;
                rl = $urandom;
                hi_q = '{rh, rh};
                lo_q = '{rl};
                do_cmd(1'b0, 64'd0, {rh, rl}, 1'b0, 4, 0);
            end
        end

        // Reset in WR_HI: the WR_LO strobe must never appear.
        wr_q.push_back('{CMP_LO, 32'hFFFF_FFFF});
        wr_q.push_back('{CMP_HI, 32'h0000_00AA});
        i_cmd_valid = 1'b1;
        i_cmd_op    = 1'b1;
        i_cmd_wdata = 64'h0000_00AA_0000_00BB;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        n = 0;
        while (!(o_wen && o_addr == CMP_HI) && n < 10) begin @(negedge clk); n++; end
        check_val("reach_wr_hi", 64'(o_wen && o_addr == CMP_HI), 64'd1);
        #2 i_rst = 1'b0;
        #1 check_idle_outputs("async_rst");
        repeat (2) @(negedge clk);
        check_val("rst_hold_wen", 64'(o_wen), 64'd0);
        #2 i_rst = 1'b1;
        @(negedge clk);
        check_val("ready_after_abort", 64'(o_cmd_ready), 64'd1);
        check_val("wr_after_abort", 64'(wr_q.size()), 64'd0);

        hi_q = '{32'hC, 32'hC};
        lo_q = '{32'hD};
        do_cmd(1'b0, 64'd0, 64'h0000_000C_0000_000D, 1'b0, 4, 0);

        check_val("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
